// File: rtl/crc_stream_engine_if.sv
// crc_stream_engine_if: word-input and result-output handshakes of the CRC engine.
// The engine uses the slave modport; a word source / result consumer uses master.
interface crc_stream_engine_if #(
   parameter int CRC_W  = 32,
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_first;
   logic              in_last;
   logic [CRC_W-1:0]  crc_i;
   logic              out_valid;
   logic              out_ready;
   logic [CRC_W-1:0]  crc_o;
   logic              crc_ok;

   modport master (
      output in_valid, in_data, in_first, in_last, crc_i, out_ready,
      input  in_ready, out_valid, crc_o, crc_ok
   );

   modport slave (
      input  in_valid, in_data, in_first, in_last, crc_i, out_ready,
      output in_ready, out_valid, crc_o, crc_ok
   );
endinterface

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised multi-word CRC generator/checker.
// Frames of DATA_W-bit words are divided MSB-first by a runtime polynomial,
// BPC bits per clock, as augmented long division (init 0, no reflection,
// no final XOR). Check mode appends the received CRC instead of zeros.
// Optional failed-check counter output err_cnt: define CRC_ERRCNT_EN.
module crc_stream_engine #(
   parameter int CRC_W  = 32,
   parameter int DATA_W = 32,
   parameter int BPC    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CRC_W:0]     poly_i,
   input  logic               mode_i,
   input  logic               clear_i,
   crc_stream_engine_if.slave bus,
   output logic               busy
`ifdef CRC_ERRCNT_EN
   ,
   output logic [15:0]        err_cnt
`endif
);

   localparam int D       = DATA_W / BPC;
   localparam int C       = CRC_W / BPC;
   localparam int CNT_MAX = (D > C) ? D : C;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   generate
      if ((DATA_W % BPC) != 0 || (CRC_W % BPC) != 0) begin : gBadBpc
         $error("crc_stream_engine: BPC must divide both DATA_W and CRC_W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, DATA, FLUSH, DONE} state_t;

   state_t              state_q, state_d;
   logic [CRC_W-1:0]    rem_q, rem_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CRC_W-1:0]    poly_q, poly_d;
   logic                mode_q, mode_d;
   logic [CRC_W-1:0]    aug_q, aug_d;
   logic                last_q, last_d;
   logic                inReady;
   logic                accept;
   logic [BPC-1:0]      augBits;
   logic                unusedPolyMsb;

   // The x^CRC_W term is implied by the shift-out feedback, so the top bit is never used
   assign unusedPolyMsb = poly_i[CRC_W];

   // One division step per bit, MSB of the chunk first, chained BPC times
   function automatic logic [CRC_W-1:0] crcStep(input logic [CRC_W-1:0] r,
                                                input logic [BPC-1:0]   b,
                                                input logic [CRC_W-1:0] p);
      logic [CRC_W-1:0] acc;
      acc = r;
      for (int i = BPC - 1; i >= 0; i--) begin
         acc = {acc[CRC_W-2:0], b[i]} ^ (acc[CRC_W-1] ? p : '0);
      end
      return acc;
   endfunction

   assign inReady       = (state_q == IDLE) && !clear_i && rst;
   assign accept        = bus.in_valid && inReady;
   assign bus.in_ready  = inReady;
   assign bus.out_valid = (state_q == DONE);
   assign bus.crc_o     = (state_q == DONE) ? rem_q : '0;
   assign bus.crc_ok    = (state_q == DONE) && mode_q && (rem_q == '0);
   assign busy          = (state_q != IDLE);
   assign augBits       = mode_q ? aug_q[CRC_W-1 -: BPC] : '0;

   // Next-state logic: load a word, shift its bits, flush augment bits, hold the result
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      poly_d  = poly_q;
      mode_d  = mode_q;
      aug_d   = aug_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = bus.in_data;
               last_d  = bus.in_last;
               cnt_d   = '0;
               state_d = DATA;
               if (bus.in_first) begin
                  rem_d  = '0;
                  poly_d = poly_i[CRC_W-1:0];
                  mode_d = mode_i;
               end
               if (bus.in_last) begin
                  aug_d = bus.crc_i;
               end
            end
         end
         DATA: begin
            rem_d   = crcStep(rem_q, shift_q[DATA_W-1 -: BPC], poly_q);
            shift_d = shift_q << BPC;
            if (cnt_q == CNT_W'(D - 1)) begin
               cnt_d   = '0;
               state_d = last_q ? FLUSH : IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FLUSH: begin
            rem_d = crcStep(rem_q, augBits, poly_q);
            aug_d = aug_q << BPC;
            if (cnt_q == CNT_W'(C - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               rem_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         rem_d   = '0;
         cnt_d   = '0;
      end
   end

   // State and datapath registers, returned to zero/IDLE on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         poly_q  <= '0;
         mode_q  <= 1'b0;
         aug_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         poly_q  <= poly_d;
         mode_q  <= mode_d;
         aug_q   <= aug_d;
         last_q  <= last_d;
      end
   end

`ifdef CRC_ERRCNT_EN
   logic [15:0] errCnt_q, errCnt_d;

   // Count failed checks at the result handshake, saturating; clear wipes the count
   always_comb begin
      errCnt_d = errCnt_q;
      if (clear_i) begin
         errCnt_d = '0;
      end else if ((state_q == DONE) && bus.out_ready && mode_q && (rem_q != '0)
                   && (errCnt_q != 16'hFFFF)) begin
         errCnt_d = errCnt_q + 16'd1;
      end
   end

   // Error counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         errCnt_q <= '0;
      end else begin
         errCnt_q <= errCnt_d;
      end
   end

   assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: self-checking bench for crc_stream_engine.
// Two instances: dutA with BPC=1 and dutB with BPC=8 (both 32-bit CRC/data).
// Expected CRCs come from a polynomial long-division model over the whole frame.
`timescale 1ns/1ps
module tb_crc_stream_engine;

   localparam int CW = 32;
   localparam int DW = 32;
   localparam logic [32:0] CRC32_POLY = 33'h104C11DB7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [32:0] poly = '0;
   logic        mode = 1'b0;
   logic        clear = 1'b0;
   logic        busyA, busyB;
`ifdef CRC_ERRCNT_EN
   logic [15:0] errA, errB;
`endif

   int nChecks = 0;
   int nFails = 0;
   int edgeCnt = 0;
   int acceptEdge = 0;

   crc_stream_engine_if #(.CRC_W(CW), .DATA_W(DW)) busA ();
   crc_stream_engine_if #(.CRC_W(CW), .DATA_W(DW)) busB ();

   crc_stream_engine #(.CRC_W(CW), .DATA_W(DW), .BPC(1)) dutA (
      .clk(clk), .rst(rst), .poly_i(poly), .mode_i(mode), .clear_i(clear),
      .bus(busA), .busy(busyA)
`ifdef CRC_ERRCNT_EN
      , .err_cnt(errA)
`endif
   );

   crc_stream_engine #(.CRC_W(CW), .DATA_W(DW), .BPC(8)) dutB (
      .clk(clk), .rst(rst), .poly_i(poly), .mode_i(mode), .clear_i(clear),
      .bus(busB), .busy(busyB)
`ifdef CRC_ERRCNT_EN
      , .err_cnt(errB)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // Remainder of the frame polynomial (data words, then received CRC or zeros) mod P
   function automatic logic [31:0] refCrc(input logic [31:0] words[$], input bit chk,
                                          input logic [31:0] rcv, input logic [31:0] polyLow);
      logic [255:0] dividend;
      int nbits;
      dividend = '0;
      foreach (words[k]) dividend = (dividend << 32) | 256'(words[k]);
      dividend = (dividend << 32) | 256'(chk ? rcv : 32'h0);
      nbits = 32 * (words.size() + 1);
      for (int i = nbits - 1; i >= 32; i--) begin
         if (dividend[i]) dividend ^= (256'({1'b1, polyLow}) << (i - 32));
      end
      return dividend[31:0];
   endfunction

   task automatic sendWord(input bit onB, input logic [31:0] data, input bit first,
                           input bit last, input logic [31:0] crcIn, output bit ok);
      logic r;
      if (onB) begin
         busB.in_data = data; busB.in_first = first; busB.in_last = last;
         busB.crc_i = crcIn; busB.in_valid = 1'b1;
      end else begin
         busA.in_data = data; busA.in_first = first; busA.in_last = last;
         busA.crc_i = crcIn; busA.in_valid = 1'b1;
      end
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         r = onB ? busB.in_ready : busA.in_ready;
         @(posedge clk);
         #1;
         ok = r;
      end
      if (onB) busB.in_valid = 1'b0; else busA.in_valid = 1'b0;
      acceptEdge = edgeCnt;
   endtask

   task automatic waitResult(input bit onB, output int lat, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = onB ? busB.out_valid : busA.out_valid;
      end
      lat = edgeCnt - acceptEdge;
   endtask

   task automatic consume(input bit onB);
      if (onB) busB.out_ready = 1'b1; else busA.out_ready = 1'b1;
      @(posedge clk);
      #1;
      busA.out_ready = 1'b0;
      busB.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      busA.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nChecks++; if (busA.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_in_ready got %b want 0", busA.in_ready); end
      nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid got %b want 0", busA.out_valid); end
      nChecks++; if (busA.crc_o !== 32'h0) begin nFails++; $display("[TB] FAIL reset_crc_o got %h want 0", busA.crc_o); end
      nChecks++; if (busA.crc_ok !== 1'b0) begin nFails++; $display("[TB] FAIL reset_crc_ok got %b want 0", busA.crc_ok); end
      nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busyA); end
`ifdef CRC_ERRCNT_EN
      nChecks++; if (errA !== 16'h0) begin nFails++; $display("[TB] FAIL reset_err_cnt got %0d want 0", errA); end
`endif
      busA.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      nChecks++; if (busA.in_ready !== 1'b1 || busyA !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_idle got ready=%b busy=%b want ready=1 busy=0", busA.in_ready, busyA); end
   endtask

   task automatic test_generate();
      bit ok;
      int lat;
      poly = CRC32_POLY; mode = 1'b0;
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h0, ok);
      nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL gen_accept got timeout want accept"); end
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || lat != 64) begin nFails++; $display("[TB] FAIL gen_latency got %0d (valid=%b) want 64", lat, ok); end
      nChecks++; if (busA.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL gen_crc_one got %h want 04c11db7", busA.crc_o); end
      nChecks++; if (busA.crc_ok !== 1'b0) begin nFails++; $display("[TB] FAIL gen_crc_ok got %b want 0", busA.crc_ok); end
      consume(1'b0);
      nChecks++; if (busyA !== 1'b0 || busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL gen_handshake got busy=%b valid=%b want 0 0", busyA, busA.out_valid); end
      sendWord(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, ok);
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || busA.crc_o !== 32'h0) begin nFails++; $display("[TB] FAIL gen_crc_zero got %h (valid=%b) want 00000000", busA.crc_o, ok); end
      consume(1'b0);
   endtask

   task automatic test_two_word();
      bit ok;
      int lat, n;
      poly = CRC32_POLY; mode = 1'b0;
      sendWord(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, ok);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (busA.in_ready) break;
      end
      nChecks++; if (n != 32) begin nFails++; $display("[TB] FAIL two_word_ready_gap got %0d want 32", n); end
      sendWord(1'b0, 32'h1, 1'b0, 1'b1, 32'h0, ok);
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || lat != 64 || busA.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL two_word_crc got %h lat %0d want 04c11db7 lat 64", busA.crc_o, lat); end
      consume(1'b0);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int lat, firstEdge;
      poly = CRC32_POLY; mode = 1'b0;
      sendWord(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, ok);
      firstEdge = acceptEdge;
      sendWord(1'b0, 32'h1, 1'b0, 1'b1, 32'h0, ok);
      nChecks++; if (acceptEdge - firstEdge != 33) begin nFails++; $display("[TB] FAIL back_to_back_spacing got %0d want 33", acceptEdge - firstEdge); end
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || busA.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL back_to_back_crc got %h want 04c11db7", busA.crc_o); end
      consume(1'b0);
   endtask

   task automatic test_check_mode();
      bit ok;
      int lat;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      poly = CRC32_POLY; mode = 1'b1;
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h04C11DB7, ok);
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || busA.crc_ok !== 1'b1 || busA.crc_o !== 32'h0) begin nFails++; $display("[TB] FAIL check_good got ok=%b crc=%h want ok=1 crc=0", busA.crc_ok, busA.crc_o); end
      consume(1'b0);
`ifdef CRC_ERRCNT_EN
      nChecks++; if (errA !== 16'd0) begin nFails++; $display("[TB] FAIL err_cnt_good got %0d want 0", errA); end
`endif
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h04C11DB6, ok);
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || busA.crc_ok !== 1'b0 || busA.crc_o !== 32'h1) begin nFails++; $display("[TB] FAIL check_bad got ok=%b crc=%h want ok=0 crc=1", busA.crc_ok, busA.crc_o); end
      consume(1'b0);
`ifdef CRC_ERRCNT_EN
      nChecks++; if (errA !== 16'd1) begin nFails++; $display("[TB] FAIL err_cnt_bad got %0d want 1", errA); end
`endif
      mode = 1'b0;
   endtask

   task automatic test_random(input bit onB, input int frames, input int maxWords, input int expLat);
      logic [31:0] words[$];
      logic [31:0] polyLow, rcv, expCrc, gotCrc;
      bit chk, ok, gotOk;
      int n, lat;
      for (int f = 0; f < frames; f++) begin
         words.delete();
         n = $urandom_range(1, maxWords);
         for (int k = 0; k < n; k++) words.push_back($urandom);
         polyLow = $urandom;
         chk = 1'($urandom_range(0, 1));
         rcv = $urandom_range(0, 1) ? refCrc(words, 1'b0, 32'h0, polyLow) : $urandom;
         expCrc = refCrc(words, chk, rcv, polyLow);
         poly = {1'($urandom_range(0, 1)), polyLow};
         mode = chk;
         for (int k = 0; k < n; k++) begin
            sendWord(onB, words[k], k == 0, k == n - 1, (k == n - 1) ? rcv : $urandom, ok);
            poly = {1'($urandom_range(0, 1)), 32'($urandom)};
            mode = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (!ok) break;
         end
         nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL rand_accept frame %0d got timeout want accept", f); end
         lat = 0;
         if (ok) begin
            acceptEdge = acceptEdge;
            waitResult(onB, lat, ok);
         end
         gotCrc = onB ? busB.crc_o : busA.crc_o;
         gotOk  = onB ? busB.crc_ok : busA.crc_ok;
         nChecks++; if (!ok || gotCrc !== expCrc) begin nFails++; $display("[TB] FAIL rand_crc bpc%0d frame %0d got %h want %h", onB ? 8 : 1, f, gotCrc, expCrc); end
         nChecks++; if (gotOk !== (chk && expCrc == 32'h0)) begin nFails++; $display("[TB] FAIL rand_crc_ok frame %0d got %b want %b", f, gotOk, chk && expCrc == 32'h0); end
         consume(onB);
      end
      mode = 1'b0;
   endtask

   task automatic test_bpc8();
      bit ok;
      int lat;
      poly = CRC32_POLY; mode = 1'b0;
      sendWord(1'b1, 32'h1, 1'b1, 1'b1, 32'h0, ok);
      waitResult(1'b1, lat, ok);
      nChecks++; if (!ok || lat != 8) begin nFails++; $display("[TB] FAIL bpc8_latency got %0d want 8", lat); end
      nChecks++; if (busB.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL bpc8_crc got %h want 04c11db7", busB.crc_o); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         nChecks++; if (busB.out_valid !== 1'b1 || busB.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL bpc8_stall cycle %0d got valid=%b crc=%h want 1 04c11db7", i, busB.out_valid, busB.crc_o); end
      end
      consume(1'b1);
      nChecks++; if (busyB !== 1'b0 || busB.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bpc8_idle got busy=%b valid=%b want 0 0", busyB, busB.out_valid); end
   endtask

   task automatic test_clear();
      bit ok, sawValid;
      int lat;
      poly = CRC32_POLY; mode = 1'b0;
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h0, ok);
      repeat (40) @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (busA.out_valid) sawValid = 1'b1;
      end
      nChecks++; if (sawValid || busyA !== 1'b0) begin nFails++; $display("[TB] FAIL clear_flush got valid_seen=%b busy=%b want 0 0", sawValid, busyA); end
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h0, ok);
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || busA.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL clear_next_frame got %h want 04c11db7", busA.crc_o); end
      consume(1'b0);
      busA.in_data = 32'h1; busA.in_first = 1'b1; busA.in_last = 1'b1;
      busA.in_valid = 1'b1; clear = 1'b1;
      @(negedge clk);
      nChecks++; if (busA.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL clear_blocks_ready got %b want 0", busA.in_ready); end
      @(posedge clk);
      #1;
      busA.in_valid = 1'b0; clear = 1'b0;
      nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL clear_no_accept got busy=%b want 0", busyA); end
   endtask

   task automatic test_reset_mid();
      bit ok, sawValid;
      int lat;
      poly = CRC32_POLY; mode = 1'b0;
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h0, ok);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      nChecks++; if (busyA !== 1'b0 || busA.in_ready !== 1'b0 || busA.out_valid !== 1'b0 || busA.crc_o !== 32'h0 || busA.crc_ok !== 1'b0) begin
         nFails++; $display("[TB] FAIL reset_mid got busy=%b ready=%b valid=%b crc=%h ok=%b want all 0", busyA, busA.in_ready, busA.out_valid, busA.crc_o, busA.crc_ok);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (busA.out_valid) sawValid = 1'b1;
      end
      nChecks++; if (sawValid) begin nFails++; $display("[TB] FAIL reset_mid_no_result got valid_seen=1 want 0"); end
      sendWord(1'b0, 32'h1, 1'b1, 1'b1, 32'h0, ok);
      waitResult(1'b0, lat, ok);
      nChecks++; if (!ok || lat != 64 || busA.crc_o !== 32'h04C11DB7) begin nFails++; $display("[TB] FAIL reset_mid_next got %h lat %0d want 04c11db7 lat 64", busA.crc_o, lat); end
      consume(1'b0);
   endtask

   initial begin
      busA.in_valid = 1'b0; busA.in_data = '0; busA.in_first = 1'b0; busA.in_last = 1'b0;
      busA.crc_i = '0; busA.out_ready = 1'b0;
      busB.in_valid = 1'b0; busB.in_data = '0; busB.in_first = 1'b0; busB.in_last = 1'b0;
      busB.crc_i = '0; busB.out_ready = 1'b0;
      test_reset();
      test_generate();
      test_two_word();
      test_back_to_back();
      test_check_mode();
      test_random(1'b0, 20, 4, 64);
      test_bpc8();
      test_random(1'b1, 8, 3, 8);
      test_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
